// File: rtl/gpr_file_if.sv
// ---------------------------------------------------------------------------
// gpr_file_if : bus bundle between the datapath control and the register file.
//
//  master : the controller side (drives write, read requests and clr_req)
//  slave  : the register file side (returns read data/valid, busy, err)
//
//  Signals
//   wr_en, wr_addr, wr_data     write port
//   rd0_en, rd0_addr            read request, port 0
//   rd0_data, rd0_valid         registered read result, port 0
//   rd1_en, rd1_addr            read request, port 1
//   rd1_data, rd1_valid         registered read result, port 1
//   clr_req                     start a hardware clear sweep
//   busy                        clear sweep in progress
//   err                         sticky out-of-range access flag
// ---------------------------------------------------------------------------
interface gpr_file_if #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd0_en;
  logic [ADDR_W-1:0] rd0_addr;
  logic [DATA_W-1:0] rd0_data;
  logic              rd0_valid;
  logic              rd1_en;
  logic [ADDR_W-1:0] rd1_addr;
  logic [DATA_W-1:0] rd1_data;
  logic              rd1_valid;
  logic              clr_req;
  logic              busy;
  logic              err;

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd0_en, rd0_addr, rd1_en, rd1_addr,
    output clr_req,
    input  rd0_data, rd0_valid, rd1_data, rd1_valid,
    input  busy, err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd0_en, rd0_addr, rd1_en, rd1_addr,
    input  clr_req,
    output rd0_data, rd0_valid, rd1_data, rd1_valid,
    output busy, err
  );
endinterface

// File: rtl/gpr_file.sv
// ---------------------------------------------------------------------------
// gpr_file : parametrised general-purpose register file.
//
//  One write port, two independent registered read ports with write-to-read
//  bypass, a sticky out-of-range error flag and a clear sequencer that
//  rewrites RESET_VAL into one register per cycle.
//
//  Ports
//   clk  : clock, all state changes on its rising edge
//   rst  : synchronous reset, active high, overrides everything
//   bus  : gpr_file_if.slave (write/read ports, clr_req, busy, err)
//
//  DATA_W / ADDR_W must match the parameters of the connected interface.
// ---------------------------------------------------------------------------
module gpr_file #(
  parameter int                DATA_W    = 10,
  parameter int                DEPTH     = 10,
  parameter int                ADDR_W    = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic     clk,
  input  logic     rst,
  gpr_file_if.slave bus
);

  // One extra bit so that DEPTH == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic              busy_reg;
  logic              err_reg;
  logic [DATA_W-1:0] regs [DEPTH];

  logic [DATA_W-1:0] rd_data_reg  [2];
  logic              rd_valid_reg [2];

  // Read ports folded into arrays so both are built by the same logic.
  logic              rd_en        [2];
  logic [ADDR_W-1:0] rd_addr      [2];
  logic              rd_oor       [2];
  logic [DATA_W-1:0] rd_data_next [2];

  logic wr_oor;
  logic wr_fire;
  logic err_hit;

  assign rd_en[0]   = bus.rd0_en;
  assign rd_addr[0] = bus.rd0_addr;
  assign rd_en[1]   = bus.rd1_en;
  assign rd_addr[1] = bus.rd1_addr;

  assign wr_oor  = ({1'b0, bus.wr_addr} >= DEPTH_X);
  // A write lands only in IDLE and only if a clear is not being accepted
  // on the same edge.
  assign wr_fire = (state_reg == IDLE) && bus.wr_en && !bus.clr_req && !wr_oor;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      assign rd_oor[gi] = ({1'b0, rd_addr[gi]} >= DEPTH_X);
      // Bypass returns the value being written on this same edge.
      assign rd_data_next[gi] =
        rd_oor[gi]                                  ? '0          :
        (wr_fire && (bus.wr_addr == rd_addr[gi]))   ? bus.wr_data :
                                                      regs[rd_addr[gi]];
    end
  endgenerate

  assign err_hit = (bus.wr_en && wr_oor)
                 | (rd_en[0] && rd_oor[0])
                 | (rd_en[1] && rd_oor[1]);

  // Register array: write port and clear sweep share the single update path.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= RESET_VAL;
      end
    end else if (wr_fire) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end else if (state_reg == CLEAR) begin
      regs[idx_reg] <= RESET_VAL;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      busy_reg  <= 1'b0;
      err_reg   <= 1'b0;
      for (int p = 0; p < 2; p++) begin
        rd_data_reg[p]  <= '0;
        rd_valid_reg[p] <= 1'b0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          for (int p = 0; p < 2; p++) begin
            rd_valid_reg[p] <= rd_en[p];
            if (rd_en[p]) begin
              rd_data_reg[p] <= rd_data_next[p];
            end
          end
          if (bus.clr_req) begin
            // Accepting a clear drops any concurrent write and wipes err.
            state_reg <= CLEAR;
            idx_reg   <= '0;
            busy_reg  <= 1'b1;
            err_reg   <= 1'b0;
          end else if (err_hit) begin
            err_reg <= 1'b1;
          end
        end
        CLEAR: begin
          for (int p = 0; p < 2; p++) begin
            rd_valid_reg[p] <= 1'b0;
          end
          if (idx_reg == LAST_IDX) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            idx_reg   <= '0;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          idx_reg   <= '0;
        end
      endcase
    end
  end

  assign bus.rd0_data  = rd_data_reg[0];
  assign bus.rd0_valid = rd_valid_reg[0];
  assign bus.rd1_data  = rd_data_reg[1];
  assign bus.rd1_valid = rd_valid_reg[1];
  assign bus.busy      = busy_reg;
  assign bus.err       = err_reg;

endmodule
